// File: rtl/cam_sccb_pkg.sv
// Shared types, constants and helpers for the SCCB camera config sequencer.
// CAM_CFG_SOFT_RESET_EN adds the soft-reset preamble states.
package cam_sccb_pkg;

  localparam logic [7:0] SOFT_RESET_REG = 8'h12;
  localparam logic [7:0] SOFT_RESET_VAL = 8'h80;
  localparam int         BITS_PER_XFER  = 27;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_SEND,
    S_GAP,
    S_FIN
`ifdef CAM_CFG_SOFT_RESET_EN
    ,
    S_SRST,
    S_SSEND,
    S_SWAIT
`endif
  } seq_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_START,
    P_SEND,
    P_STOP,
    P_GAP
  } phy_state_t;

  function automatic int qdiv_calc(input int clk_hz, input int sccb_hz);
    int q;
    q = clk_hz / (4 * sccb_hz);
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/cam_sccb_cfg_seq_phy.sv
// sccb_write_phy: quarter-tick generator and one 3-phase SCCB write
// (START, 27 bits, STOP, idle gap) driven as open-drain enables.
module sccb_write_phy
  import cam_sccb_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int SCCB_HZ  = 100000,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] payload,
  output logic        ready,
  output logic        scl_oe,
  output logic        sda_oe
);

  localparam int QDIV = qdiv_calc(CLK_HZ, SCCB_HZ);
  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);
  localparam logic [4:0] BLAST = 5'(BITS_PER_XFER - 1);
  localparam logic [4:0] GLAST = 5'(GAP_BITS - 1);

  phy_state_t  state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]  quarter, quarter_n;
  logic [4:0]  bitcnt, bitcnt_n;
  logic [3:0]  pos, pos_n;
  logic [23:0] sh, sh_n;
  logic        qtick;
  logic        scl_n, sda_n;

  assign ready = (state == P_IDLE);
  assign qtick = (qcnt == QLAST);

  always_comb begin
    state_n   = state;
    qcnt_n    = qcnt;
    quarter_n = quarter;
    bitcnt_n  = bitcnt;
    pos_n     = pos;
    sh_n      = sh;
    if (state == P_IDLE) begin
      qcnt_n = '0;
      if (go) begin
        state_n   = P_START;
        quarter_n = '0;
        bitcnt_n  = '0;
        pos_n     = '0;
        sh_n      = payload;
      end
    end else begin
      qcnt_n = qtick ? '0 : qcnt + 1'b1;
      if (qtick) begin
        quarter_n = quarter + 2'd1;
        unique case (state)
          P_START: begin
            if (quarter == 2'd1) begin
              state_n   = P_SEND;
              quarter_n = '0;
            end
          end
          P_SEND: begin
            if (quarter == 2'd3) begin
              // 9th bit of each byte is don't-care: no shift
              if (pos == 4'd8) begin
                pos_n = '0;
              end else begin
                pos_n = pos + 4'd1;
                sh_n  = {sh[22:0], 1'b0};
              end
              if (bitcnt == BLAST) begin
                state_n  = P_STOP;
                bitcnt_n = '0;
              end else begin
                bitcnt_n = bitcnt + 5'd1;
              end
            end
          end
          P_STOP: begin
            if (quarter == 2'd2) begin
              quarter_n = '0;
              state_n   = (GAP_BITS == 0) ? P_IDLE : P_GAP;
            end
          end
          P_GAP: begin
            if (quarter == 2'd3) begin
              if (bitcnt == GLAST) state_n = P_IDLE;
              else bitcnt_n = bitcnt + 5'd1;
            end
          end
          default: state_n = P_IDLE;
        endcase
      end
    end
  end

  // Pin levels follow the slot being entered so the pads are registered
  always_comb begin
    scl_n = 1'b0;
    sda_n = 1'b0;
    unique case (state_n)
      P_START: sda_n = 1'b1;
      P_SEND: begin
        scl_n = (quarter_n == 2'd0) || (quarter_n == 2'd3);
        sda_n = (pos_n != 4'd8) && !sh_n[23];
      end
      P_STOP: begin
        scl_n = (quarter_n == 2'd0);
        sda_n = (quarter_n != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= P_IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bitcnt  <= '0;
      pos     <= '0;
      sh      <= '0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      quarter <= quarter_n;
      bitcnt  <= bitcnt_n;
      pos     <= pos_n;
      sh      <= sh_n;
      scl_oe  <= scl_n;
      sda_oe  <= sda_n;
    end
  end

endmodule

// File: rtl/cam_sccb_cfg_seq.sv
// Camera register-table sequencer: one SCCB write per {addr,val} entry.
// Build option CAM_CFG_SOFT_RESET_EN: soft-reset write + 1 ms settle first.
module cam_sccb_cfg_seq
  import cam_sccb_pkg::*;
#(
  parameter int         CLK_HZ   = 12000000,
  parameter int         SCCB_HZ  = 100000,
  parameter logic [7:0] DEV_ADDR = 8'h42,
  parameter int         NUM_REGS = 16,
  parameter int         GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tbl_idx,
  input  logic [15:0] tbl_data,
  output logic        scl_oe,
  output logic        sda_oe
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

  seq_state_t  state, state_n;
  logic [7:0]  idx_n;
  logic        go;
  logic [23:0] payload;
  logic        ready;

`ifdef CAM_CFG_SOFT_RESET_EN
  localparam int SRST_CYC = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int SW = $clog2(SRST_CYC + 1);
  localparam logic [SW-1:0] SLAST = SW'(SRST_CYC - 1);
  logic [SW-1:0] scnt;
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

  always_comb begin
    state_n = state;
    idx_n   = tbl_idx;
    go      = 1'b0;
    payload = {DEV_ADDR, tbl_data};
    unique case (state)
      S_IDLE: begin
        if (start) begin
          idx_n = '0;
`ifdef CAM_CFG_SOFT_RESET_EN
          state_n = S_SRST;
`else
          state_n = S_FETCH;
`endif
        end
      end
      // ROM output lags tbl_idx by one cycle
      S_FETCH: state_n = S_START;
      S_START: begin
        go      = 1'b1;
        state_n = S_SEND;
      end
      S_SEND: if (ready) state_n = S_GAP;
      S_GAP: begin
        if (tbl_idx == LAST_IDX) begin
          state_n = S_FIN;
        end else begin
          idx_n   = tbl_idx + 8'd1;
          state_n = S_FETCH;
        end
      end
      S_FIN: state_n = S_IDLE;
`ifdef CAM_CFG_SOFT_RESET_EN
      S_SRST: begin
        go      = 1'b1;
        payload = {DEV_ADDR, SOFT_RESET_REG, SOFT_RESET_VAL};
        state_n = S_SSEND;
      end
      S_SSEND: if (ready) state_n = S_SWAIT;
      S_SWAIT: if (scnt == SLAST) state_n = S_FETCH;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tbl_idx <= '0;
    end else begin
      state   <= state_n;
      tbl_idx <= idx_n;
    end
  end

`ifdef CAM_CFG_SOFT_RESET_EN
  always_ff @(posedge clk) begin
    if (reset || state != S_SWAIT) scnt <= '0;
    else scnt <= scnt + 1'b1;
  end
`endif

  sccb_write_phy #(
    .CLK_HZ  (CLK_HZ),
    .SCCB_HZ (SCCB_HZ),
    .GAP_BITS(GAP_BITS)
  ) u_phy (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .payload(payload),
    .ready  (ready),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe)
  );

endmodule

// File: tb/tb_cam_sccb_cfg_seq.sv
// Bench for cam_sccb_cfg_seq: random tables, bus-level decoder monitor
// and an expected-transaction scoreboard.
module tb_cam_sccb_cfg_seq;

  localparam int CLK_HZ   = 800000;
  localparam int SCCB_HZ  = 100000;
  localparam int NUM_REGS = 16;
  localparam int GAP_BITS = 2;
  localparam int QDIV     = CLK_HZ / (4 * SCCB_HZ);
  localparam int GAP_CYC  = GAP_BITS * 4 * QDIV;
  localparam int SRST_CYC = CLK_HZ / 1000;
  localparam logic [7:0] DEV = 8'h42;
`ifdef CAM_CFG_SOFT_RESET_EN
  localparam int SR = 1;
`else
  localparam int SR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, scl_oe, sda_oe;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_data = '0;

  always #5 clk = ~clk;

  cam_sccb_cfg_seq #(
    .CLK_HZ  (CLK_HZ),
    .SCCB_HZ (SCCB_HZ),
    .DEV_ADDR(DEV),
    .NUM_REGS(NUM_REGS),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .tbl_idx (tbl_idx),
    .tbl_data(tbl_data),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe)
  );

  logic [15:0] tbl [NUM_REGS];
  always @(posedge clk) tbl_data <= tbl[tbl_idx[3:0]];

  typedef struct {
    logic [23:0] v;
    bit          srst;
  } xfer_t;
  xfer_t exp_q[$];

  int tests = 0;
  int fails = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endfunction

  function automatic void chk_rng(string n, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", n, act, lo, hi);
    end
  endfunction

  // Bus monitor: decodes START/bits/STOP from the open-drain levels
  bit          prev_scl = 1, prev_sda = 1;
  bit          in_xfer = 0, have_stop = 0, after_srst = 0;
  int          nbits = 0, idle_cnt = 0, since_stop = 0;
  int          xfers = 0, dones = 0;
  logic [27:0] mbits = '0;
  logic [7:0]  idx_at_start = '0;

  always @(negedge clk) begin
    bit scl, sda;
    xfer_t e;
    scl = !scl_oe;
    sda = !sda_oe;
    since_stop++;
    if (reset) begin
      in_xfer    = 0;
      have_stop  = 0;
      after_srst = 0;
      idle_cnt   = 0;
    end else begin
      if (scl && sda) idle_cnt++;
      if (prev_scl && scl && prev_sda && !sda) begin
        chk("start_outside_xfer", in_xfer, 0);
        if (after_srst) chk_rng("srst_idle", idle_cnt, SRST_CYC, 1 << 30);
        else if (have_stop) chk_rng("gap_idle", idle_cnt, GAP_CYC, 1 << 30);
        after_srst   = 0;
        in_xfer      = 1;
        nbits        = 0;
        idle_cnt     = 0;
        idx_at_start = tbl_idx;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        chk("stop_inside_xfer", in_xfer, 1);
        chk("bit_count", nbits, 28);
        chk("x_bits_released", {mbits[19], mbits[10], mbits[1]}, 3'b111);
        chk("idx_stable", tbl_idx, idx_at_start);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got %06h, expected none",
                   {mbits[27:20], mbits[18:11], mbits[9:2]});
        end else begin
          e = exp_q.pop_front();
          chk("xfer_data", {mbits[27:20], mbits[18:11], mbits[9:2]}, e.v);
          after_srst = e.srst;
        end
        in_xfer    = 0;
        have_stop  = 1;
        xfers++;
        since_stop = 0;
        idle_cnt   = 1;
      end else if (in_xfer && !prev_scl && scl) begin
        nbits++;
        mbits = {mbits[26:0], sda};
      end
      if (done) begin
        dones++;
        chk("done_all_xfers", exp_q.size(), 0);
        chk("done_bus_idle", in_xfer, 0);
        chk_rng("done_after_gap", since_stop, GAP_CYC, GAP_CYC + QDIV + 6);
        have_stop = 0;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_tbl();
    for (int i = 0; i < NUM_REGS; i++)
      tbl[i] = {4'(i), 4'($urandom), 8'($urandom)};
  endtask

  task automatic push_pass();
    if (SR == 1) exp_q.push_back('{v: {DEV, 8'h12, 8'h80}, srst: 1'b1});
    for (int i = 0; i < NUM_REGS; i++)
      exp_q.push_back('{v: {DEV, tbl[i]}, srst: 1'b0});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfers < target && n < budget) begin
      tick();
      n++;
    end
    chk("xfer_wait_timeout", xfers >= target, 1);
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (dones == base && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", dones != base, 1);
  endtask

  initial begin
    int x0, d0, n;
    fill_tbl();

    // reset held with start high: nothing may launch
    reset = 1'b1;
    start = 1'b1;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_idx", tbl_idx, 0);
    reset = 1'b0;
    start = 1'b0;
    tick(300);
    chk("no_xfer_after_rst", xfers, 0);
    chk("idle_after_rst", busy, 0);

    // plain full pass
    x0 = xfers;
    d0 = dones;
    push_pass();
    pulse_start();
    chk("busy_on_start", busy, 1);
    chk("idx_on_start", tbl_idx, 0);
    wait_done(d0, 12000);
    tick(300);
    chk("pass_xfers", xfers - x0, NUM_REGS + SR);
    chk("pass_done_once", dones - d0, 1);
    chk("pass_busy_clear", busy, 0);

    // start while busy is ignored
    fill_tbl();
    x0 = xfers;
    d0 = dones;
    push_pass();
    pulse_start();
    wait_xfers(x0 + SR + 5, 6000);
    pulse_start();
    wait_done(d0, 12000);
    tick(300);
    chk("busy_start_xfers", xfers - x0, NUM_REGS + SR);
    chk("busy_start_done_once", dones - d0, 1);

    // reset in the middle of bit 13 of a transaction
    fill_tbl();
    x0 = xfers;
    push_pass();
    pulse_start();
    n = 0;
    while (!(xfers >= x0 + SR + 1 && in_xfer && nbits == 14) && n < 8000) begin
      tick();
      n++;
    end
    chk("midbit_reached", in_xfer && nbits == 14, 1);
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("midrst_scl", scl_oe, 0);
    chk("midrst_sda", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick(50);
    chk("midrst_quiet", busy, 0);

    // restart after abandoned pass begins again at entry 0
    fill_tbl();
    x0 = xfers;
    d0 = dones;
    push_pass();
    pulse_start();
    chk("restart_idx", tbl_idx, 0);
    wait_done(d0, 12000);
    tick(300);
    chk("restart_xfers", xfers - x0, NUM_REGS + SR);
    chk("restart_done_once", dones - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
